// File: rtl/rnd_harvester.sv
// rnd_harvester: drives the entropy cell's G control, resynchronises its R
// output, von Neumann debiases raw samples, packs them MSB-first into bytes
// behind a valid/ready port and runs a repetition-count health test.
module rnd_harvester #(
  parameter int EXCITE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int REP_LIMIT     = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ENABLE,
  input  logic       RAW,
  output logic       GEN_G,
  output logic [7:0] RND,
  output logic       RND_VALID,
  input  logic       RND_READY,
  output logic       HEALTH_FAIL
);

  localparam int CYC_MAX = (EXCITE_CYCLES > SETTLE_CYCLES) ? EXCITE_CYCLES : SETTLE_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX) + 1;
  localparam int RUN_W   = $clog2(REP_LIMIT) + 1;

  localparam logic [CYC_W-1:0] EXC_LAST = CYC_W'(EXCITE_CYCLES - 1);
  localparam logic [CYC_W-1:0] SET_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [RUN_W-1:0] REP_LIM  = RUN_W'(REP_LIMIT);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXCITE,
    ST_SETTLE,
    ST_WAIT,
    ST_FAIL
  } state_t;

  state_t           state_q;
  state_t           state_nx;
  logic [CYC_W-1:0] cyc_q;

  logic             raw_sync_p0;
  logic             raw_sync_p1;

  logic             prev_q;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_nx;

  logic             phase_q;
  logic             first_q;
  logic [7:0]       acc_q;
  logic [2:0]       fill_q;

  logic             capture;
  logic             trip;
  logic             out_free;
  logic             bit_vld;
  logic             byte_done;
  logic [7:0]       byte_val;
  logic             load;
  logic [7:0]       load_val;

  // Run counter increment that sticks at the repetition limit.
  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] c);
    return (c >= REP_LIM) ? REP_LIM : c + RUN_ONE;
  endfunction

  // Capture happens on the edge that ends the last SETTLE cycle.
  assign capture   = (state_q == ST_SETTLE) && (cyc_q == SET_LAST);
  assign run_nx    = ((run_q != '0) && (raw_sync_p1 == prev_q)) ? run_sat_inc(run_q) : RUN_ONE;
  assign trip      = capture && (run_nx == REP_LIM);
  assign out_free  = !RND_VALID || RND_READY;
  // A differing pair yields its first sample as the debiased bit (10 -> 1, 01 -> 0).
  assign bit_vld   = capture && phase_q && (first_q != raw_sync_p1);
  assign byte_done = bit_vld && (fill_q == 3'd7);
  assign byte_val  = {acc_q[6:0], first_q};
  // In WAIT the finished byte is parked in the accumulator.
  assign load      = (capture && !trip && byte_done && out_free) ||
                     ((state_q == ST_WAIT) && out_free);
  assign load_val  = (state_q == ST_WAIT) ? acc_q : byte_val;

  // Two-flop resynchronizer for the asynchronous entropy bit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      raw_sync_p0 <= 1'b0;
      raw_sync_p1 <= 1'b0;
    end else begin
      raw_sync_p0 <= RAW;
      raw_sync_p1 <= raw_sync_p0;
    end
  end

  // State register, per-state cycle counter and registered G control.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      GEN_G   <= 1'b1;
    end else begin
      state_q <= state_nx;
      GEN_G   <= (state_nx != ST_EXCITE);
      if (state_nx != state_q) begin
        cyc_q <= '0;
      end else if ((state_q == ST_EXCITE) || (state_q == ST_SETTLE)) begin
        cyc_q <= cyc_q + CYC_ONE;
      end
    end
  end

  // Next-state logic for the sampling sequence.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE:   if (ENABLE) state_nx = ST_EXCITE;
      ST_EXCITE: if (cyc_q == EXC_LAST) state_nx = ST_SETTLE;
      ST_SETTLE: begin
        if (capture) begin
          if (trip)                        state_nx = ST_FAIL;
          else if (byte_done && !out_free) state_nx = ST_WAIT;
          else                             state_nx = ST_IDLE;
        end
      end
      ST_WAIT:   if (out_free) state_nx = ST_IDLE;
      ST_FAIL:   state_nx = ST_FAIL;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Repetition-count health test on every captured raw sample.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_q      <= 1'b0;
      run_q       <= '0;
      HEALTH_FAIL <= 1'b0;
    end else if (capture) begin
      prev_q <= raw_sync_p1;
      run_q  <= run_nx;
      if (trip) HEALTH_FAIL <= 1'b1;
    end
  end

  // Pair tracking and MSB-first packing of debiased bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase_q <= 1'b0;
      first_q <= 1'b0;
      acc_q   <= '0;
      fill_q  <= '0;
    end else if (capture) begin
      if (trip) begin
        phase_q <= 1'b0;
        acc_q   <= '0;
        fill_q  <= '0;
      end else begin
        phase_q <= ~phase_q;
        if (!phase_q) first_q <= raw_sync_p1;
        if (bit_vld) begin
          acc_q  <= byte_val;
          fill_q <= fill_q + 3'd1;
        end
      end
    end
  end

  // Output register: load a finished byte, clear on acceptance, drop on health trip.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RND       <= '0;
      RND_VALID <= 1'b0;
    end else if (trip) begin
      RND_VALID <= 1'b0;
    end else if (load) begin
      RND       <= load_val;
      RND_VALID <= 1'b1;
    end else if (RND_VALID && RND_READY) begin
      RND_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rnd_harvester.sv
// Scoreboard bench for rnd_harvester: directed raw-bit streams with expected
// bytes (value and edge number) queued at stimulus time and popped by a
// monitor thread whenever the DUT presents a new byte.
module tb_rnd_harvester;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       ENABLE = 1'b0;
  logic       RAW = 1'b0;
  logic       RND_READY = 1'b0;
  logic       GEN_G;
  logic [7:0] RND;
  logic       RND_VALID;
  logic       HEALTH_FAIL;

  typedef struct {
    logic [7:0] d;
    int         e;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n;
  logic [1:0] disc_pairs [16];

  rnd_harvester dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .ENABLE      (ENABLE),
    .RAW         (RAW),
    .GEN_G       (GEN_G),
    .RND         (RND),
    .RND_VALID   (RND_VALID),
    .RND_READY   (RND_READY),
    .HEALTH_FAIL (HEALTH_FAIL)
  );

  always #5 CLK = ~CLK;

  // Edge numbering: edge 1 is the first rising edge after reset release.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Sample k (1-based) of a byte sent as debiased pairs: bit 1 -> 10, bit 0 -> 01.
  function automatic logic pat_bit(input logic [7:0] b, input int k);
    int   i;
    logic bv;
    i  = (k - 1) / 2;
    bv = b[7-i];
    return ((k - 1) % 2 == 0) ? bv : ~bv;
  endfunction

  // Hold one raw value for a full 7-cycle sample window.
  task automatic sample(input logic v);
    RAW = v;
    repeat (7) @(posedge CLK);
    #1;
  endtask

  task automatic feed_byte(input logic [7:0] b);
    for (int k = 1; k <= 16; k++) sample(pat_bit(b, k));
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Pops the scoreboard whenever a new byte appears on the output port.
  task automatic monitor();
    logic pv;
    logic pa;
    exp_t x;
    pv = 1'b0;
    pa = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        pv = 1'b0;
        pa = 1'b0;
      end else begin
        if (RND_VALID && (!pv || pa)) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rnd_unexpected actual=0x%0h required=no byte (edge %0d)", RND, edge_n);
          end else begin
            x = sb_q.pop_front();
            chk("rnd_data", 32'(RND), 32'(x.d));
            chk("rnd_edge", 32'(edge_n), 32'(x.e));
          end
        end
        pv = RND_VALID;
        pa = RND_VALID && RND_READY;
      end
    end
  endtask

  initial begin
    int cnt;
    int f_edge;
    disc_pairs = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11, 2'b01,
                   2'b00, 2'b10, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b10};
    fork
      monitor();
    join_none
    fork
      begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Basic byte 0xAA with the consumer always ready
    do_reset();
    chk("reset_gen_g", 32'(GEN_G), 32'h1);
    chk("reset_rnd", 32'(RND), 32'h0);
    chk("reset_valid", 32'(RND_VALID), 32'h0);
    chk("reset_health", 32'(HEALTH_FAIL), 32'h0);
    RND_READY = 1'b1;
    ENABLE    = 1'b1;
    sb_q.push_back('{d: 8'hAA, e: 112});
    feed_byte(8'hAA);

    // Asynchronous reset in the middle of EXCITE
    @(posedge CLK); #1;
    chk("excite_gen_g", 32'(GEN_G), 32'h0);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_async_gen_g", 32'(GEN_G), 32'h1);
    chk("rst_async_rnd", 32'(RND), 32'h0);
    chk("rst_async_valid", 32'(RND_VALID), 32'h0);
    chk("rst_async_health", 32'(HEALTH_FAIL), 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    chk("sb_empty_basic", 32'(sb_q.size()), 32'h0);

    // Discarded 00/11 pairs interleaved with 01,01,01,01,10,10,10,10
    do_reset();
    RND_READY = 1'b1;
    sb_q.push_back('{d: 8'h0F, e: 224});
    for (int i = 0; i < 16; i++) begin
      sample(disc_pairs[i][1]);
      sample(disc_pairs[i][0]);
    end
    repeat (2) @(posedge CLK); #1;
    chk("sb_empty_discard", 32'(sb_q.size()), 32'h0);

    // Backpressure across two bytes
    do_reset();
    RND_READY = 1'b0;
    sb_q.push_back('{d: 8'hAA, e: 112});
    feed_byte(8'hAA);
    feed_byte(8'h55);
    chk("bp_hold_rnd", 32'(RND), 32'hAA);
    chk("bp_hold_valid", 32'(RND_VALID), 32'h1);
    cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (GEN_G !== 1'b1) cnt++;
    end
    chk("bp_wait_gen_g_low_cycles", 32'(cnt), 32'h0);
    chk("bp_wait_rnd", 32'(RND), 32'hAA);
    @(posedge CLK); #1;
    f_edge    = edge_n;
    RND_READY = 1'b1;
    sb_q.push_back('{d: 8'h55, e: f_edge + 1});
    @(posedge CLK); #1;
    RND_READY = 1'b0;
    chk("bp_swap_rnd", 32'(RND), 32'h55);
    chk("bp_swap_valid", 32'(RND_VALID), 32'h1);
    @(posedge CLK); #1;
    chk("bp_resume_excite", 32'(GEN_G), 32'h0);
    RND_READY = 1'b1;
    repeat (2) @(posedge CLK); #1;
    chk("bp_drain_valid", 32'(RND_VALID), 32'h0);
    chk("sb_empty_bp", 32'(sb_q.size()), 32'h0);

    // Health trip with a pending byte: 0xAA then a run of 1s
    do_reset();
    RND_READY = 1'b0;
    sb_q.push_back('{d: 8'hAA, e: 112});
    feed_byte(8'hAA);
    repeat (14) sample(1'b1);
    RAW = 1'b1;
    repeat (6) @(posedge CLK); #1;
    chk("hf_pre_edge", 32'(edge_n), 32'd216);
    chk("hf_pre_flag", 32'(HEALTH_FAIL), 32'h0);
    chk("hf_pre_valid", 32'(RND_VALID), 32'h1);
    @(posedge CLK); #1;
    chk("hf_trip_flag", 32'(HEALTH_FAIL), 32'h1);
    chk("hf_trip_valid", 32'(RND_VALID), 32'h0);
    chk("hf_trip_gen_g", 32'(GEN_G), 32'h1);
    cnt = 0;
    repeat (30) begin
      @(posedge CLK); #1;
      RAW       = ~RAW;
      RND_READY = ~RND_READY;
      @(negedge CLK);
      if (GEN_G !== 1'b1 || HEALTH_FAIL !== 1'b1 || RND_VALID !== 1'b0) cnt++;
    end
    chk("hf_absorb_bad_cycles", 32'(cnt), 32'h0);
    chk("sb_empty_health", 32'(sb_q.size()), 32'h0);

    // ENABLE dropped mid-SETTLE of sample 6, then resumed
    do_reset();
    RND_READY = 1'b1;
    ENABLE    = 1'b1;
    for (int k = 1; k <= 5; k++) sample(pat_bit(8'hAA, k));
    RAW = pat_bit(8'hAA, 6);
    repeat (5) @(posedge CLK);
    #1 ENABLE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (GEN_G !== 1'b1) cnt++;
    end
    chk("en_idle_gen_g_low_cycles", 32'(cnt), 32'h0);
    @(posedge CLK); #1;
    f_edge = edge_n;
    ENABLE = 1'b1;
    sb_q.push_back('{d: 8'hAA, e: f_edge + 70});
    for (int k = 7; k <= 16; k++) sample(pat_bit(8'hAA, k));
    repeat (3) @(posedge CLK); #1;
    chk("sb_empty_enable", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
